led_mode_ctrl: RTL and testbench
================================

// Module: led_mode_ctrl
// PURPOSE
//  Sequencer for the 4-bit board LED bank. It debounces two raw push-buttons
//  (mode, pause) and divides sys_clk into a step tick. A mode FSM selects
//  the LED pattern (blink, chase, bounce, off) that advances on each tick.
//  Sits between the board buttons and the LED pins; replaces free-running blinkers.
// PARAMETERS
//  TICK_DIV      25_000_000  sys_clk cycles per pattern step (>=2)
//  DEBOUNCE_CYC  1_000_000   cycles a synced button must be stable to be accepted (>=1)
//  PWM_DUTY      16          on-slots per 16-cycle PWM frame, 0..16 (used only with LED_PWM_DIM_EN)
// PORTS
//  sys_clk    in   1  system clock
//  rst_n      in   1  asynchronous, active-low reset
//  btn_mode   in   1  raw mode button, active high, asynchronous
//  btn_pause  in   1  raw pause button, active high, asynchronous
//  led        out  4  LED drive, 1 = lit
//  mode       out  2  current mode: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 OFF
//  paused     out  1  1 = pattern frozen
//  step_tick  out  1  one-cycle pulse on each pattern step
// BEHAVIOUR
//  Reset (async assert, sync release): led=0000, mode=0, paused=0, step_tick=0,
//   all counters, synchronisers, debounced levels and the bounce direction cleared.
//  Button path, per button: 2-FF synchroniser, then a debounce counter.
//   The counter resets whenever the synced value differs from the debounced level.
//   When it has differed for DEBOUNCE_CYC consecutive cycles, the level updates.
//   A debounced 0->1 transition gives a 1-cycle press pulse. Release gives no pulse.
//   Holding a button produces exactly one press.
//  Tick: tick_cnt counts 0..TICK_DIV-1 while paused=0.
//   step_tick=1 in the cycle after tick_cnt==TICK_DIV-1, and tick_cnt wraps to 0.
//   While paused=1, tick_cnt holds its value and step_tick=0.
//  Pause press: toggles paused. Resume continues from the held tick_cnt.
//  Mode press: mode <= mode+1, wrapping 3->0. In the same cycle:
//   tick_cnt cleared, bounce direction set to up, led loads the entry pattern:
//   BLINK 0000, CHASE 0001, BOUNCE 0001, OFF 0000.
//   A mode press while paused changes mode and pattern; paused stays 1.
//  Step actions, when the tick fires:
//   BLINK   led <= ~led.
//   CHASE   rotate left: 0001->0010->0100->1000->0001.
//   BOUNCE  shift in the current direction.
//           On reaching 1000 the direction flips to down; on reaching 0001 it flips to up.
//           Endpoints are never repeated: ...0100,1000,0100,0010,0001,0010...
//   OFF     led stays 0000; the tick still runs.
//  Simultaneous events:
//   mode press and tick firing in the same cycle: the mode press wins and the step is discarded.
//   mode and pause presses together: both take effect.
//  step_tick is registered; led changes in the same cycle step_tick is high.
// CONFIGURATION
//  LED_PWM_DIM_EN defined:
//   a free-running 4-bit pwm_cnt (reset 0) runs even while paused.
//   led = pattern & {4{pwm_cnt < PWM_DUTY}}, so brightness = PWM_DUTY/16.
//   PWM_DUTY=0 keeps all LEDs dark; PWM_DUTY=16 keeps them fully on.
//  LED_PWM_DIM_EN undefined: led = pattern register directly, no pwm_cnt, PWM_DUTY ignored.
// TESTING (bench params TICK_DIV=4, DEBOUNCE_CYC=3, macro undefined unless noted)
//  1 Release reset, no buttons -> mode=0, step_tick every 4th cycle, led toggles 0000/1111 on each tick.
//  2 Hold btn_mode 10 cycles -> one press, mode=1, led=0001.
//    Next ticks: 0010,0100,1000,0001. Three more presses -> mode 2, 3, then 0.
//  3 mode=2 -> led per tick: 0001,0010,0100,1000,0100,0010,0001,0010.
//  4 btn_pause glitches of 1-2 cycles, repeated for 40 cycles -> no press, paused=0.
//    A 6-cycle hold -> paused=1.
//  5 paused=1 for 50 cycles -> led constant, step_tick=0.
//    Second pause press -> ticks resume from the held tick_cnt.
//    Mode press while paused -> new entry pattern, paused stays 1.
//  6 Assert rst_n mid-CHASE at led=0100 -> led=0000, mode=0, paused=0 immediately.
//    With LED_PWM_DIM_EN and PWM_DUTY=4: a lit LED is high exactly 4 of every 16 cycles.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// LED bank sequencer: debounced mode/pause buttons, step-tick divider, pattern FSM.
// Optional PWM dimming of the LED outputs when LED_PWM_DIM_EN is defined.
module led_mode_ctrl #(
  parameter int unsigned TICK_DIV     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned PWM_DUTY     = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       step_tick
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYC - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 1");
  end
  if (PWM_DUTY > 16) begin : g_bad_pwm_duty
    $error("PWM_DUTY must be in 0..16");
  end

  typedef enum logic [1:0] {
    ModeBlink  = 2'd0,
    ModeChase  = 2'd1,
    ModeBounce = 2'd2,
    ModeOff    = 2'd3
  } mode_e;

  // Button path; bit 0 = mode, bit 1 = pause.
  logic [1:0]          btn_raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          level_q, level_d;
  logic [1:0]          press;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;

  assign btn_raw = {btn_pause, btn_mode};

  // Counter tracks how long the synced input has disagreed with the accepted level.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          level_d[i] = sync2_q[i];
          press[i]   = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Pattern sequencer.
  mode_e            mode_q, mode_d;
  logic             paused_q, paused_d;
  logic             step_q, step_d;
  logic             dir_down_q, dir_down_d;
  logic [3:0]       pattern_q, pattern_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_fire;
  logic             mode_press, pause_press;

  assign mode_press  = press[0];
  assign pause_press = press[1];
  assign tick_fire   = !paused_q && (tick_cnt_q == TickMax);

  always_comb begin
    mode_d     = mode_q;
    paused_d   = paused_q ^ pause_press;
    step_d     = 1'b0;
    dir_down_d = dir_down_q;
    pattern_d  = pattern_q;
    tick_cnt_d = tick_cnt_q;

    if (!paused_q) begin
      tick_cnt_d = tick_fire ? '0 : tick_cnt_q + 1'b1;
    end

    // A mode press overrides a coincident step.
    if (mode_press) begin
      mode_d     = mode_e'(mode_q + 2'd1);
      tick_cnt_d = '0;
      dir_down_d = 1'b0;
      case (mode_d)
        ModeChase, ModeBounce: pattern_d = 4'b0001;
        default:               pattern_d = 4'b0000;
      endcase
    end else if (tick_fire) begin
      step_d = 1'b1;
      unique case (mode_q)
        ModeBlink: pattern_d = ~pattern_q;
        ModeChase: pattern_d = {pattern_q[2:0], pattern_q[3]};
        ModeBounce: begin
          pattern_d = dir_down_q ? (pattern_q >> 1) : (pattern_q << 1);
          if (pattern_d == 4'b1000) begin
            dir_down_d = 1'b1;
          end else if (pattern_d == 4'b0001) begin
            dir_down_d = 1'b0;
          end
        end
        ModeOff: pattern_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= ModeBlink;
      paused_q   <= 1'b0;
      step_q     <= 1'b0;
      dir_down_q <= 1'b0;
      pattern_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      paused_q   <= paused_d;
      step_q     <= step_d;
      dir_down_q <= dir_down_d;
      pattern_q  <= pattern_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign mode      = mode_q;
  assign paused    = paused_q;
  assign step_tick = step_q;

`ifdef LED_PWM_DIM_EN
  localparam logic [4:0] PwmDuty = 5'(PWM_DUTY);
  logic [3:0] pwm_cnt_q;

  // Free-running frame counter; keeps dimming active while paused.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end
  end

  assign led = pattern_q & {4{({1'b0, pwm_cnt_q} < PwmDuty)}};
`else
  assign led = pattern_q;
`endif

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with small TICK_DIV/DEBOUNCE_CYC.
// Expected step patterns are queued before each wait and popped when step_tick fires.
module tb_led_mode_ctrl;

  logic       sys_clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       step_tick;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_led_q[$];
  int         exp_gap_q[$];

  led_mode_ctrl #(
    .TICK_DIV    (4),
    .DEBOUNCE_CYC(3),
    .PWM_DUTY    (16)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_pause(btn_pause),
    .led      (led),
    .mode     (mode),
    .paused   (paused),
    .step_tick(step_tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected step, wait (bounded) for step_tick, then pop and compare.
  task automatic wait_step(input logic [3:0] led_exp, input int gap_exp, input string tag);
    int         n;
    bit         seen;
    logic [3:0] e_led;
    int         e_gap;
    exp_led_q.push_back(led_exp);
    exp_gap_q.push_back(gap_exp);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge sys_clk);
      n++;
      seen = (step_tick === 1'b1);
    end
    e_led = exp_led_q.pop_front();
    e_gap = exp_gap_q.pop_front();
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_led"}, 32'(led), 32'(e_led));
    check({tag, "_gap"}, 32'(n), 32'(e_gap));
  endtask

  // Press latency: 2 synchroniser stages + 3 debounce cycles.
  task automatic wait_mode(input logic [1:0] m_exp, input string tag);
    int n;
    n = 0;
    while (mode !== m_exp && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_mode"}, 32'(mode), 32'(m_exp));
    check({tag, "_lat"}, 32'(n), 32'd5);
  endtask

  task automatic wait_paused(input logic p_exp, input string tag);
    int n;
    n = 0;
    while (paused !== p_exp && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_paused"}, 32'(paused), 32'(p_exp));
    check({tag, "_lat"}, 32'(n), 32'd5);
  endtask

  task automatic release_all();
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask

  initial begin
    int chg;
    int stp;
    rst_n     = 1'b0;
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_step", 32'(step_tick), 32'd0);
    rst_n = 1'b1;

    // Blink from reset.
    wait_step(4'b1111, 4, "blink0");
    wait_step(4'b0000, 4, "blink1");
    wait_step(4'b1111, 4, "blink2");
    wait_step(4'b0000, 4, "blink3");

    // Held mode button: one press, chase runs while still held.
    btn_mode = 1'b1;
    wait_mode(2'd1, "to_chase");
    check("chase_entry", 32'(led), 32'b0001);
    wait_step(4'b0010, 4, "chase0");
    wait_step(4'b0100, 4, "chase1");
    wait_step(4'b1000, 4, "chase2");
    wait_step(4'b0001, 4, "chase3");
    check("hold_one_press", 32'(mode), 32'd1);
    release_all();
    check("release_no_press", 32'(mode), 32'd1);

    // Bounce.
    btn_mode = 1'b1;
    wait_mode(2'd2, "to_bounce");
    check("bounce_entry", 32'(led), 32'b0001);
    wait_step(4'b0010, 4, "bounce0");
    wait_step(4'b0100, 4, "bounce1");
    wait_step(4'b1000, 4, "bounce2");
    wait_step(4'b0100, 4, "bounce3");
    wait_step(4'b0010, 4, "bounce4");
    wait_step(4'b0001, 4, "bounce5");
    wait_step(4'b0010, 4, "bounce6");
    release_all();

    // Off: tick keeps running, LEDs dark.
    btn_mode = 1'b1;
    wait_mode(2'd3, "to_off");
    check("off_entry", 32'(led), 32'd0);
    wait_step(4'b0000, 4, "off0");
    wait_step(4'b0000, 4, "off1");
    release_all();

    // Wrap back to blink.
    btn_mode = 1'b1;
    wait_mode(2'd0, "wrap_blink");
    check("wrap_entry", 32'(led), 32'd0);
    wait_step(4'b1111, 4, "wrap0");
    wait_step(4'b0000, 4, "wrap1");
    release_all();

    // Pause glitches never stable for 3 synced cycles.
    repeat (8) begin
      btn_pause = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk);
      btn_pause = 1'b0;
      @(negedge sys_clk);
      btn_pause = 1'b1;
      @(negedge sys_clk);
      btn_pause = 1'b0;
      @(negedge sys_clk);
    end
    repeat (6) @(negedge sys_clk);
    check("glitch_paused", 32'(paused), 32'd0);
    check("glitch_mode", 32'(mode), 32'd0);

    // Known chase position, then pause right after a step; one more step lands first.
    btn_mode = 1'b1;
    wait_mode(2'd1, "chase_again");
    wait_step(4'b0010, 4, "pre_pause");
    btn_pause = 1'b1;
    wait_paused(1'b1, "pause_on");
    check("pause_led", 32'(led), 32'b0100);
    btn_pause = 1'b0;
    btn_mode  = 1'b0;
    chg = 0;
    stp = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (led !== 4'b0100) chg++;
      if (step_tick !== 1'b0) stp++;
    end
    check("paused_led_changes", 32'(chg), 32'd0);
    check("paused_steps", 32'(stp), 32'd0);
    check("still_paused", 32'(paused), 32'd1);

    // Resume: tick_cnt was held at 1, so the first step comes 3 cycles later.
    btn_pause = 1'b1;
    wait_paused(1'b0, "pause_off");
    wait_step(4'b1000, 3, "resume0");
    wait_step(4'b0001, 4, "resume1");
    release_all();

    // Mode press while paused.
    btn_pause = 1'b1;
    wait_paused(1'b1, "pause2_on");
    btn_pause = 1'b0;
    btn_mode  = 1'b1;
    wait_mode(2'd2, "paused_mode");
    check("paused_mode_led", 32'(led), 32'b0001);
    check("paused_mode_paused", 32'(paused), 32'd1);
    chg = 0;
    stp = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (led !== 4'b0001) chg++;
      if (step_tick !== 1'b0) stp++;
    end
    check("paused2_led_changes", 32'(chg), 32'd0);
    check("paused2_steps", 32'(stp), 32'd0);
    release_all();

    // Back to chase, then asynchronous reset at led=0100.
    btn_pause = 1'b1;
    wait_paused(1'b0, "pause2_off");
    release_all();
    btn_mode = 1'b1;
    wait_mode(2'd3, "cyc_off");
    release_all();
    btn_mode = 1'b1;
    wait_mode(2'd0, "cyc_blink");
    release_all();
    btn_mode = 1'b1;
    wait_mode(2'd1, "cyc_chase");
    check("cyc_chase_entry", 32'(led), 32'b0001);
    wait_step(4'b0010, 4, "pre_rst0");
    wait_step(4'b0100, 4, "pre_rst1");
    btn_mode = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_paused", 32'(paused), 32'd0);
    check("async_rst_step", 32'(step_tick), 32'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    wait_step(4'b1111, 4, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
